sd_cmd_phy: RTL and testbench

Parametrised SD-host CMD-line physical layer: the successor of the fixed 48-bit CMD engine. It serialises a 40-bit command plus a generated CRC7 onto the CMD pin, then waits for and captures either a short (48-bit) or long (136-bit) response, selected per command. It flags timeout and, optionally, CRC errors, and enforces a minimum inter-command gap. It sits between the SD host command controller (strobe/ack handshakes) and the CMD pad.

---
 rtl/sd_cmd_phy.sv | 209 ++++++++++++++++++++
 tb/tb_sd_cmd_phy.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_phy.sv
// SD host CMD-line PHY: serialises a 40-bit command plus CRC7 and captures a 48/136-bit response.
// Optional receive CRC7 checker compiled in with `define SD_CMD_CRC_CHECK_EN (crc_error tied 0 otherwise).
module sd_cmd_phy #(
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int NCC_CYCLES      = 8,
    parameter int SHORT_RESP_BITS = 48,
    parameter int LONG_RESP_BITS  = 136
) (
    input  logic                      sd_clock,
    input  logic                      reset,
    input  logic                      strobe_in,
    input  logic [39:0]               cmd_to_send,
    input  logic                      no_response,
    input  logic                      long_resp,
    input  logic                      ack_in,
    input  logic                      idle_in,
    input  logic                      cmd_pin_in,
    output logic                      ack_out,
    output logic                      strobe_out,
    output logic [LONG_RESP_BITS-1:0] response,
    output logic                      command_timeout,
    output logic                      crc_error,
    output logic                      cmd_pin_out,
    output logic                      cmd_oe
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = ($clog2(NCC_CYCLES + 1) > 0) ? $clog2(NCC_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_RESP,
        S_RECV,
        S_DONE,
        S_GAP
    } state_t;

    state_t                    state_q;
    logic [39:0]               cmd_q;
    logic                      no_resp_q;
    logic                      long_q;
    logic [7:0]                bit_cnt_q;
    logic [TW-1:0]             tmo_cnt_q;
    logic [GW-1:0]             gap_cnt_q;
    logic [LONG_RESP_BITS-1:0] resp_q;
    logic                      ack_q;
    logic                      strobe_q;
    logic                      tmo_q;
    logic                      pin_q;
    logic                      oe_q;

    // CRC7, generator x^7 + x^3 + 1, one bit per call, MSB first.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = crc[6] ^ b;
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
        return c;
    endfunction

    logic [47:0] tx_frame;
    logic [7:0]  rx_last;

    assign tx_frame = {cmd_q, crc7_40(cmd_q), 1'b1};
    assign rx_last  = long_q ? 8'(LONG_RESP_BITS - 1) : 8'(SHORT_RESP_BITS - 1);

`ifdef SD_CMD_CRC_CHECK_EN
    logic [6:0] rx_crc_q;
    logic       crc_err_q;
    logic       rx_in_range;

    // Long (R2) frames exclude the 8-bit header from the CRC; short frames cover bits 0..39.
    assign rx_in_range = long_q ? (bit_cnt_q >= 8'd8 && bit_cnt_q <= 8'd127)
                                : (bit_cnt_q <= 8'd39);
    assign crc_error   = crc_err_q;
`else
    assign crc_error   = 1'b0;
`endif

    // NOTE: every register here updates with non-blocking assignments so all
    // next-state decisions read the pre-edge values, whatever the statement order.
    always_ff @(posedge sd_clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cmd_q     <= '0;
            no_resp_q <= 1'b0;
            long_q    <= 1'b0;
            bit_cnt_q <= '0;
            tmo_cnt_q <= '0;
            gap_cnt_q <= '0;
            resp_q    <= '0;
            ack_q     <= 1'b0;
            strobe_q  <= 1'b0;
            tmo_q     <= 1'b0;
            pin_q     <= 1'b1;
            oe_q      <= 1'b0;
`ifdef SD_CMD_CRC_CHECK_EN
            rx_crc_q  <= '0;
            crc_err_q <= 1'b0;
`endif
        end else if (idle_in) begin
            state_q  <= S_IDLE;
            resp_q   <= '0;
            ack_q    <= 1'b0;
            strobe_q <= 1'b0;
            tmo_q    <= 1'b0;
            pin_q    <= 1'b1;
            oe_q     <= 1'b0;
`ifdef SD_CMD_CRC_CHECK_EN
            crc_err_q <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (strobe_in) begin
                        cmd_q     <= cmd_to_send;
                        no_resp_q <= no_response;
                        long_q    <= long_resp;
                        ack_q     <= 1'b1;
                        oe_q      <= 1'b1;
                        pin_q     <= cmd_to_send[39];
                        bit_cnt_q <= 8'd1;
                        resp_q    <= '0;
                        tmo_q     <= 1'b0;
`ifdef SD_CMD_CRC_CHECK_EN
                        crc_err_q <= 1'b0;
`endif
                        state_q   <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (bit_cnt_q == 8'd48) begin
                        oe_q  <= 1'b0;
                        pin_q <= 1'b1;
                        if (no_resp_q) begin
                            strobe_q <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            tmo_cnt_q <= '0;
                            state_q   <= S_WAIT_RESP;
                        end
                    end else begin
                        pin_q     <= tx_frame[6'd47 - bit_cnt_q[5:0]];
                        bit_cnt_q <= bit_cnt_q + 8'd1;
                    end
                end
                S_WAIT_RESP: begin
                    // The start bit itself is a 0 shifted into a cleared register, so resp_q is untouched.
                    if (!cmd_pin_in) begin
                        bit_cnt_q <= 8'd1;
`ifdef SD_CMD_CRC_CHECK_EN
                        rx_crc_q  <= '0;
`endif
                        state_q   <= S_RECV;
                    end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        tmo_q    <= 1'b1;
                        strobe_q <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TW'(1);
                    end
                end
                S_RECV: begin
                    resp_q <= {resp_q[LONG_RESP_BITS-2:0], cmd_pin_in};
`ifdef SD_CMD_CRC_CHECK_EN
                    if (rx_in_range) rx_crc_q <= crc7_step(rx_crc_q, cmd_pin_in);
`endif
                    if (bit_cnt_q == rx_last) begin
                        strobe_q <= 1'b1;
                        state_q  <= S_DONE;
`ifdef SD_CMD_CRC_CHECK_EN
                        // After this shift the received CRC lands in resp[7:1] for both frame lengths.
                        crc_err_q <= (rx_crc_q != resp_q[6:0]);
`endif
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 8'd1;
                    end
                end
                S_DONE: begin
                    if (ack_in) begin
                        strobe_q  <= 1'b0;
                        gap_cnt_q <= '0;
                        state_q   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == GW'(NCC_CYCLES - 1)) state_q <= S_IDLE;
                    else gap_cnt_q <= gap_cnt_q + GW'(1);
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ack_out         = ack_q;
    assign strobe_out      = strobe_q;
    assign response        = resp_q;
    assign command_timeout = tmo_q;
    assign cmd_pin_out     = pin_q;
    assign cmd_oe          = oe_q;

endmodule

// File: tb/tb_sd_cmd_phy.sv
// Self-checking bench for sd_cmd_phy: result frames go through a scoreboard queue,
// handshake and cycle timing are checked inline in each scenario task.
module tb_sd_cmd_phy;

    localparam int TIMEOUT_CYCLES = 64;
    localparam int NCC_CYCLES     = 8;

    logic         sd_clock = 1'b0;
    logic         reset;
    logic         strobe_in;
    logic [39:0]  cmd_to_send;
    logic         no_response;
    logic         long_resp;
    logic         ack_in;
    logic         idle_in;
    logic         cmd_pin_in;
    logic         ack_out;
    logic         strobe_out;
    logic [135:0] response;
    logic         command_timeout;
    logic         crc_error;
    logic         cmd_pin_out;
    logic         cmd_oe;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [135:0] resp;
        logic         tmo;
        logic         crc;
    } exp_t;

    exp_t sb_q[$];

`ifdef SD_CMD_CRC_CHECK_EN
    localparam logic CRC_EN = 1'b1;
`else
    localparam logic CRC_EN = 1'b0;
`endif

    sd_cmd_phy #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .NCC_CYCLES     (NCC_CYCLES),
        .SHORT_RESP_BITS(48),
        .LONG_RESP_BITS (136)
    ) dut (
        .sd_clock       (sd_clock),
        .reset          (reset),
        .strobe_in      (strobe_in),
        .cmd_to_send    (cmd_to_send),
        .no_response    (no_response),
        .long_resp      (long_resp),
        .ack_in         (ack_in),
        .idle_in        (idle_in),
        .cmd_pin_in     (cmd_pin_in),
        .ack_out        (ack_out),
        .strobe_out     (strobe_out),
        .response       (response),
        .command_timeout(command_timeout),
        .crc_error      (crc_error),
        .cmd_pin_out    (cmd_pin_out),
        .cmd_oe         (cmd_oe)
    );

    always #5 sd_clock = ~sd_clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    // Reference CRC7 over the low n bits of v, MSB first (polynomial division by x^7+x^3+1).
    function automatic logic [6:0] crc7_model(input logic [135:0] v, input int n);
        logic [7:0] r;
        r = 8'h00;
        for (int i = n - 1; i >= 0; i--) begin
            r = {r[6:0], v[i]};
            if (r[7]) r = r ^ 8'h89;
        end
        for (int i = 0; i < 7; i++) begin
            r = {r[6:0], 1'b0};
            if (r[7]) r = r ^ 8'h89;
        end
        return r[6:0];
    endfunction

    // Scoreboard monitor: each rising strobe_out pops one expected result.
    logic strobe_prev = 1'b0;
    always @(negedge sd_clock) begin
        if (strobe_out && !strobe_prev) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: strobe_out rose with no expected entry, response=%h", response);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                total++;
                if (response !== e.resp) begin
                    bad++;
                    $display("FAIL resp_data: got %h want %h", response, e.resp);
                end
                total++;
                if (command_timeout !== e.tmo) begin
                    bad++;
                    $display("FAIL resp_timeout: got %b want %b", command_timeout, e.tmo);
                end
                total++;
                if (crc_error !== e.crc) begin
                    bad++;
                    $display("FAIL resp_crc_error: got %b want %b", crc_error, e.crc);
                end
            end
        end
        strobe_prev = strobe_out;
    end

    task automatic step();
        @(posedge sd_clock);
        #1;
    endtask

    // Raise strobe_in, wait for ack_out, collect the 48 serialised bits. Ends in the end-bit cycle.
    task automatic send_cmd(input logic [39:0] cmd, input logic nr, input logic lr,
                            output int ack_wait, output logic [47:0] bits, output logic oe_all);
        cmd_to_send = cmd;
        no_response = nr;
        long_resp   = lr;
        strobe_in   = 1'b1;
        ack_wait    = 0;
        do begin
            step();
            ack_wait++;
        end while (!ack_out && ack_wait < 100);
        strobe_in = 1'b0;
        bits      = '0;
        oe_all    = 1'b1;
        if (ack_out) begin
            for (int i = 0; i < 48; i++) begin
                if (i > 0) step();
                bits   = {bits[46:0], cmd_pin_out};
                oe_all = oe_all & cmd_oe;
            end
        end else begin
            ack_wait = -1;
        end
    endtask

    // Drive a response frame (f[n-1] first) starting lead cycles after the end-bit cycle.
    task automatic drive_resp(input logic [135:0] f, input int n, input int lead, output logic strobe_early);
        repeat (lead) step();
        strobe_early = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            cmd_pin_in   = f[i];
            strobe_early = strobe_early | strobe_out;
            step();
        end
        cmd_pin_in = 1'b1;
    endtask

    task automatic release_result();
        ack_in = 1'b1;
        step();
        ack_in = 1'b0;
        repeat (NCC_CYCLES + 1) step();
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        strobe_in   = 1'b0;
        cmd_to_send = '0;
        no_response = 1'b0;
        long_resp   = 1'b0;
        ack_in      = 1'b0;
        idle_in     = 1'b0;
        cmd_pin_in  = 1'b1;
        repeat (3) step();
        total++;
        if (cmd_pin_out !== 1'b1 || cmd_oe !== 1'b0) begin
            bad++;
            $display("FAIL reset_pad: pin=%b oe=%b want pin=1 oe=0", cmd_pin_out, cmd_oe);
        end
        total++;
        if ({ack_out, strobe_out, command_timeout, crc_error} !== 4'b0000 || response !== '0) begin
            bad++;
            $display("FAIL reset_flags: ack=%b strobe=%b tmo=%b crc=%b resp=%h want all 0",
                     ack_out, strobe_out, command_timeout, crc_error, response);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_cmd0_no_resp();
        int aw;
        logic [47:0] bits;
        logic oe_all;
        sb_q.push_back('{resp: '0, tmo: 1'b0, crc: 1'b0});
        send_cmd(40'h40_0000_0000, 1'b1, 1'b0, aw, bits, oe_all);
        total++;
        if (aw !== 1) begin
            bad++;
            $display("FAIL cmd0_ack_latency: got %0d want 1", aw);
        end
        total++;
        if (bits !== 48'h4000_0000_0095) begin
            bad++;
            $display("FAIL cmd0_tx_frame: got %h want 400000000095", bits);
        end
        total++;
        if (oe_all !== 1'b1 || strobe_out !== 1'b0) begin
            bad++;
            $display("FAIL cmd0_oe_during_send: oe_all=%b strobe=%b want 1/0", oe_all, strobe_out);
        end
        step();
        total++;
        if (strobe_out !== 1'b1 || cmd_oe !== 1'b0) begin
            bad++;
            $display("FAIL cmd0_strobe_k49: strobe=%b oe=%b want 1/0", strobe_out, cmd_oe);
        end
        release_result();
    endtask

    task automatic test_short_resp();
        int aw;
        logic [47:0] bits;
        logic [47:0] exp_tx;
        logic oe_all;
        logic early;
        logic [39:0] cmd;
        logic [135:0] frame;
        cmd    = 40'h51_0000_0900;
        exp_tx = {cmd, crc7_model({96'h0, cmd}, 40), 1'b1};
        frame  = {88'h0, 8'h11, 32'h0000_0900, crc7_model({96'h0, 8'h11, 32'h0000_0900}, 40), 1'b1};
        sb_q.push_back('{resp: frame, tmo: 1'b0, crc: 1'b0});
        send_cmd(cmd, 1'b0, 1'b0, aw, bits, oe_all);
        total++;
        if (bits !== exp_tx) begin
            bad++;
            $display("FAIL cmd17_tx_frame: got %h want %h", bits, exp_tx);
        end
        drive_resp(frame, 48, 5, early);
        total++;
        if (early !== 1'b0 || strobe_out !== 1'b1) begin
            bad++;
            $display("FAIL cmd17_strobe_timing: early=%b strobe=%b want 0/1", early, strobe_out);
        end
        release_result();
    endtask

    task automatic test_long_resp();
        int aw;
        logic [47:0] bits;
        logic oe_all;
        logic early;
        logic [119:0] cid;
        logic [135:0] frame;
        logic [135:0] flip;
        cid   = 120'h03_5344_5344_3332_4780_1234_5678_0142;
        frame = {8'h3F, cid, crc7_model({16'h0, cid}, 120), 1'b1};
        flip  = 136'h8;
        for (int pass = 0; pass < 2; pass++) begin
            logic [135:0] f;
            f = (pass == 0) ? frame : (frame ^ flip);
            sb_q.push_back('{resp: f, tmo: 1'b0, crc: (pass == 1) & CRC_EN});
            send_cmd(40'h42_0000_0000, 1'b0, 1'b1, aw, bits, oe_all);
            drive_resp(f, 136, 2 + pass, early);
            total++;
            if (early !== 1'b0 || strobe_out !== 1'b1) begin
                bad++;
                $display("FAIL cmd2_strobe_timing pass=%0d: early=%b strobe=%b want 0/1", pass, early, strobe_out);
            end
            release_result();
        end
    endtask

    task automatic test_timeout();
        int aw;
        int n;
        logic [47:0] bits;
        logic oe_all;
        sb_q.push_back('{resp: '0, tmo: 1'b1, crc: 1'b0});
        send_cmd(40'h48_0000_01AA, 1'b0, 1'b0, aw, bits, oe_all);
        n = 0;
        do begin
            step();
            n++;
        end while (!strobe_out && n < 300);
        total++;
        if (n !== TIMEOUT_CYCLES + 1) begin
            bad++;
            $display("FAIL timeout_latency: strobe after %0d cycles from end bit, want %0d", n, TIMEOUT_CYCLES + 1);
        end
        release_result();
    endtask

    task automatic test_idle_abort();
        cmd_to_send = 40'h4C_0000_0000;
        no_response = 1'b1;
        long_resp   = 1'b0;
        strobe_in   = 1'b1;
        step();
        total++;
        if (ack_out !== 1'b1) begin
            bad++;
            $display("FAIL abort_first_ack: got %b want 1", ack_out);
        end
        strobe_in = 1'b0;
        repeat (20) step();
        idle_in     = 1'b1;
        strobe_in   = 1'b1;
        cmd_to_send = 40'h37_1234_5678;
        step();
        idle_in = 1'b0;
        total++;
        if (cmd_oe !== 1'b0 || cmd_pin_out !== 1'b1 || ack_out !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle_next: oe=%b pin=%b ack=%b want 0/1/0", cmd_oe, cmd_pin_out, ack_out);
        end
        step();
        total++;
        if (ack_out !== 1'b1 || cmd_oe !== 1'b1 || cmd_pin_out !== 1'b0) begin
            bad++;
            $display("FAIL abort_reaccept: ack=%b oe=%b pin=%b want 1/1/0", ack_out, cmd_oe, cmd_pin_out);
        end
        strobe_in = 1'b0;
        idle_in   = 1'b1;
        step();
        idle_in = 1'b0;
        total++;
        if (cmd_oe !== 1'b0 || strobe_out !== 1'b0) begin
            bad++;
            $display("FAIL abort_second: oe=%b strobe=%b want 0/0", cmd_oe, strobe_out);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int aw;
        int n;
        logic [47:0] bits;
        logic oe_all;
        sb_q.push_back('{resp: '0, tmo: 1'b0, crc: 1'b0});
        send_cmd(40'h40_0000_0000, 1'b1, 1'b0, aw, bits, oe_all);
        step();
        ack_in      = 1'b1;
        strobe_in   = 1'b1;
        cmd_to_send = 40'h40_0000_0000;
        no_response = 1'b1;
        step();
        ack_in = 1'b0;
        total++;
        if (strobe_out !== 1'b0 || ack_out !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ack_served: strobe=%b ack=%b want 0/0", strobe_out, ack_out);
        end
        n = 1;
        while (!ack_out && n < 50) begin
            step();
            n++;
        end
        total++;
        if (n !== NCC_CYCLES + 2) begin
            bad++;
            $display("FAIL b2b_gap_latency: ack_out %0d cycles after ack_in, want %0d", n, NCC_CYCLES + 2);
        end
        strobe_in = 1'b0;
        sb_q.push_back('{resp: '0, tmo: 1'b0, crc: 1'b0});
        repeat (48) step();
        total++;
        if (strobe_out !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second_strobe: got %b want 1", strobe_out);
        end
        release_result();
    endtask

    initial begin
        test_reset();
        test_cmd0_no_resp();
        test_short_resp();
        test_long_resp();
        test_timeout();
        test_idle_abort();
        test_back_to_back();
        repeat (4) step();
        total++;
        if (sb_q.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d results never produced, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
